// File: rtl/sdram_line_fetcher.sv
// Read-only sdram_ctl client: fetches the frame buffer in 32-word bursts into a pixel FIFO
// and streams it out as valid/ready pixels. Optional FETCH_UNDERRUN_CNT_EN adds underrun_count.
module sdram_line_fetcher #(
  parameter logic [24:0] BASE_ADDR       = 25'd0,
  parameter int          WORDS_PER_FRAME = 76800,
  parameter int          FIFO_DEPTH      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic [24:0]      ctl_addr,
  output logic             ctl_write_en,
  output logic             ctl_burst_en,
  output logic             ctl_refresh_data,
  input  logic             ctl_mem_ready,
  input  logic             ctl_data_ready,
  input  logic [31:0][15:0] ctl_burst_buf,
  output logic [15:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy
`ifdef FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_count
`endif
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = AW + 1;
  localparam int          BURST       = 32;
  localparam logic [31:0] FRAME_WORDS = WORDS_PER_FRAME;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, WAIT_DONE, COPY} state_t;

  state_t          state, state_nxt;
  logic [4:0]      idx;
  logic [31:0]     offset;
  logic            active;
  logic            restart_pend;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   count, free, count_after_pop;
  logic [15:0]     push_word;
  logic            fs_now, copy_last, flush, push, pop, start;

  assign ctl_write_en = 1'b0;
  assign ctl_burst_en = 1'b1;
  assign busy         = (state != IDLE);
  assign pix_valid    = (count != '0);

  // Before the request is out a restart is immediate; afterwards it waits for the burst to end.
  assign fs_now    = frame_start && (state == IDLE || state == REQ);
  assign copy_last = (state == COPY) && (idx == 5'd31);
  assign flush     = fs_now || (copy_last && (restart_pend || frame_start));
  assign push      = (state == COPY) && !restart_pend;
  assign pop       = pix_valid && pix_ready && !flush;
  assign start     = active && ctl_mem_ready && ctl_data_ready && (free >= CW'(BURST));
  assign push_word = ctl_burst_buf[idx];

  assign rd_nxt          = rd_ptr + AW'(pop);
  assign count_after_pop = count - CW'(pop);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt        = state;
    ctl_refresh_data = 1'b0;
    case (state)
      IDLE:      if (start && !frame_start) state_nxt = REQ;
      REQ: begin
        if (frame_start) begin
          state_nxt = IDLE;
        end else begin
          ctl_refresh_data = 1'b1;
          state_nxt        = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (!ctl_data_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (ctl_data_ready) state_nxt = COPY;
      COPY:      if (idx == 5'd31) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      offset       <= '0;
      ctl_addr     <= BASE_ADDR;
      active       <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start) active <= 1'b1;

      if (flush)            restart_pend <= 1'b0;
      else if (frame_start) restart_pend <= 1'b1;

      if (state == COPY) idx <= idx + 5'd1;
      else               idx <= '0;

      if (flush) begin
        offset   <= '0;
        ctl_addr <= BASE_ADDR;
      end else if (copy_last) begin
        if (offset + 32'(BURST) == FRAME_WORDS) begin
          offset   <= '0;
          ctl_addr <= BASE_ADDR;
        end else begin
          offset   <= offset + 32'(BURST);
          ctl_addr <= ctl_addr + 25'(BURST);
        end
      end
    end
  end

  // Slots are reserved when the request strobe goes out and returned one per pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      free     <= CW'(FIFO_DEPTH);
      pix_data <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      free     <= CW'(FIFO_DEPTH);
      pix_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= count + CW'(push) - CW'(pop);
      free   <= free + CW'(pop) - (ctl_refresh_data ? CW'(BURST) : CW'(0));
      // The head register bypasses storage when the FIFO is about to hold only the new word.
      pix_data <= (count_after_pop == '0) ? push_word : mem[rd_nxt];
    end
  end

  // NOTE: the pixel storage has no reset; pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

`ifdef FETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (frame_start) begin
      underrun_count <= '0;
    end else if (active && pix_ready && !pix_valid && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher: sdram_ctl behavioural model plus a pixel scoreboard.
// Define FETCH_UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_sdram_line_fetcher;

  localparam logic [24:0] BASE = 25'h40;
  localparam int          WPF  = 64;
  localparam int          LAT  = 6;

  logic             clk;
  logic             rst;
  logic             frame_start;
  logic [24:0]      ctl_addr;
  logic             ctl_write_en;
  logic             ctl_burst_en;
  logic             ctl_refresh_data;
  logic             ctl_mem_ready;
  logic             ctl_data_ready;
  logic [31:0][15:0] ctl_burst_buf;
  logic [15:0]      pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             busy;
`ifdef FETCH_UNDERRUN_CNT_EN
  logic [15:0]      underrun_count;
`endif

  int passes = 0;
  int checks = 0;

  sdram_line_fetcher #(
    .BASE_ADDR(BASE),
    .WORDS_PER_FRAME(WPF),
    .FIFO_DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .ctl_addr(ctl_addr),
    .ctl_write_en(ctl_write_en),
    .ctl_burst_en(ctl_burst_en),
    .ctl_refresh_data(ctl_refresh_data),
    .ctl_mem_ready(ctl_mem_ready),
    .ctl_data_ready(ctl_data_ready),
    .ctl_burst_buf(ctl_burst_buf),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .busy(busy)
`ifdef FETCH_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sdram_ctl model: accepts a strobe, drops data_ready, returns word i = addr+i after LAT cycles.
  logic        bfm_busy;
  int          bfm_cnt;
  logic [24:0] bfm_addr;
  int          req_count = 0;
  int          proto_errs = 0;
  logic [24:0] addr_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_data_ready <= 1'b1;
      bfm_busy       <= 1'b0;
      bfm_cnt        <= 0;
    end else if (ctl_refresh_data) begin
      req_count <= req_count + 1;
      addr_log.push_back(ctl_addr);
      if (bfm_busy || !ctl_mem_ready) begin
        proto_errs <= proto_errs + 1;
      end else begin
        bfm_busy       <= 1'b1;
        ctl_data_ready <= 1'b0;
        bfm_addr       <= ctl_addr;
        bfm_cnt        <= LAT;
      end
    end else if (bfm_busy) begin
      if (bfm_cnt == 0) begin
        for (int i = 0; i < 32; i++) ctl_burst_buf[i] <= 16'(bfm_addr + 25'(i));
        ctl_data_ready <= 1'b1;
        bfm_busy       <= 1'b0;
      end else begin
        bfm_cnt <= bfm_cnt - 1;
      end
    end
  end

  // Scoreboard: each observed strobe queues the 32 words its address must yield.
  logic [15:0] exp_q[$];
  logic [24:0] exp_addr;
  int          pops    = 0;
  int          strobes = 0;

  task automatic tick();
    logic [15:0] e;
    if (ctl_refresh_data) begin
      strobes++;
      checks++;
      if (ctl_addr !== exp_addr) $display("FAIL req_addr: got %0h expected %0h", ctl_addr, exp_addr);
      else passes++;
      for (int i = 0; i < 32; i++) exp_q.push_back(16'(exp_addr + 25'(i)));
      exp_addr = (exp_addr + 25'd32 == BASE + 25'(WPF)) ? BASE : exp_addr + 25'd32;
    end
    if (pix_valid && pix_ready && !frame_start) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pix_extra: got %0h expected no word", pix_data);
      end else begin
        e = exp_q.pop_front();
        if (pix_data !== e) $display("FAIL pix_data: got %0h expected %0h", pix_data, e);
        else passes++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart_frame();
    frame_start = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_strobe(input int target, input string name);
    for (int n = 0; n < 40 && req_count < target; n++) tick();
    checks++;
    if (req_count !== target) $display("FAIL %s: got %0d requests expected %0d", name, req_count, target);
    else passes++;
  endtask

  task automatic test_reset();
    checks += 7;
    if (pix_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", pix_valid); else passes++;
    if (pix_data !== 16'h0) $display("FAIL rst_data: got %0h expected 0", pix_data); else passes++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
    if (ctl_refresh_data !== 1'b0) $display("FAIL rst_strobe: got %b expected 0", ctl_refresh_data); else passes++;
    if (ctl_addr !== BASE) $display("FAIL rst_addr: got %0h expected %0h", ctl_addr, BASE); else passes++;
    if (ctl_write_en !== 1'b0) $display("FAIL write_en: got %b expected 0", ctl_write_en); else passes++;
    if (ctl_burst_en !== 1'b1) $display("FAIL burst_en: got %b expected 1", ctl_burst_en); else passes++;
  endtask

  task automatic test_first_burst();
    int r0, p0;
    ctl_mem_ready = 1'b1;
    r0 = req_count;
    restart_frame();
    wait_strobe(r0 + 1, "first_req");
    ctl_mem_ready = 1'b0;
    pix_ready = 1'b1;
    p0 = pops;
    repeat (60) tick();
    pix_ready = 1'b0;
    checks += 3;
    if (pops - p0 !== 32) $display("FAIL first_pops: got %0d expected 32", pops - p0); else passes++;
    if (pix_valid !== 1'b0) $display("FAIL first_empty: got %b expected 0", pix_valid); else passes++;
    if (strobes !== req_count) $display("FAIL strobe_width: got %0d strobe cycles expected %0d", strobes, req_count);
    else passes++;
  endtask

  task automatic test_two_bursts_wrap();
    int r0, n0;
    pix_ready = 1'b0;
    ctl_mem_ready = 1'b1;
    r0 = req_count;
    n0 = addr_log.size();
    restart_frame();
    repeat (120) tick();
    checks += 3;
    if (req_count - r0 !== 2) $display("FAIL two_bursts: got %0d expected 2", req_count - r0); else passes++;
    if (pix_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", pix_valid); else passes++;
    if (busy !== 1'b0) $display("FAIL full_idle: got %b expected 0", busy); else passes++;
    pix_ready = 1'b1;
    repeat (31) tick();
    pix_ready = 1'b0;
    repeat (60) tick();
    checks++;
    if (req_count - r0 !== 2) $display("FAIL no_third_req: got %0d expected 2", req_count - r0); else passes++;
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    wait_strobe(r0 + 3, "third_req");
    ctl_mem_ready = 1'b0;
    checks += 3;
    if (addr_log[n0] !== BASE) $display("FAIL addr0: got %0h expected %0h", addr_log[n0], BASE); else passes++;
    if (addr_log[n0+1] !== BASE + 25'd32) $display("FAIL addr1: got %0h expected %0h", addr_log[n0+1], BASE + 25'd32);
    else passes++;
    if (addr_log[n0+2] !== BASE) $display("FAIL addr_wrap: got %0h expected %0h", addr_log[n0+2], BASE); else passes++;
    repeat (50) tick();
    pix_ready = 1'b1;
    repeat (80) tick();
    pix_ready = 1'b0;
    checks += 2;
    if (pix_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", pix_valid); else passes++;
    if (exp_q.size() !== 0) $display("FAIL drain_left: got %0d expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_restart_pending();
    int r0;
    pix_ready = 1'b0;
    ctl_mem_ready = 1'b1;
    r0 = req_count;
    restart_frame();
    wait_strobe(r0 + 1, "pend_req");
    ctl_mem_ready = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int n = 0; n < 40 && !ctl_data_ready; n++) tick();
    checks++;
    if (req_count - r0 !== 1) $display("FAIL pend_no_req: got %0d expected 1", req_count - r0); else passes++;
    repeat (40) tick();
    checks += 4;
    if (pix_valid !== 1'b0) $display("FAIL pend_flush: got %b expected 0", pix_valid); else passes++;
    if (busy !== 1'b0) $display("FAIL pend_idle: got %b expected 0", busy); else passes++;
    if (ctl_addr !== BASE) $display("FAIL pend_addr: got %0h expected %0h", ctl_addr, BASE); else passes++;
    if (req_count - r0 !== 1) $display("FAIL pend_req_cnt: got %0d expected 1", req_count - r0); else passes++;
    exp_q.delete();
    exp_addr = BASE;
    ctl_mem_ready = 1'b1;
    wait_strobe(r0 + 2, "pend_restart");
    ctl_mem_ready = 1'b0;
    pix_ready = 1'b1;
    repeat (60) tick();
    pix_ready = 1'b0;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL pend_drain: got %0d expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_push_pop_same_cycle();
    int r0, p0;
    logic held;
    pix_ready = 1'b0;
    ctl_mem_ready = 1'b1;
    r0 = req_count;
    restart_frame();
    wait_strobe(r0 + 1, "pp_req1");
    ctl_mem_ready = 1'b0;
    repeat (50) tick();
    pix_ready = 1'b1;
    repeat (22) tick();
    pix_ready = 1'b0;
    ctl_mem_ready = 1'b1;
    wait_strobe(r0 + 2, "pp_req2");
    ctl_mem_ready = 1'b0;
    for (int n = 0; n < 40 && !ctl_data_ready; n++) tick();
    pix_ready = 1'b1;
    p0 = pops;
    held = 1'b1;
    for (int n = 0; n < 32; n++) begin
      if (!pix_valid) held = 1'b0;
      tick();
    end
    pix_ready = 1'b0;
    checks += 2;
    if (held !== 1'b1) $display("FAIL pp_valid_held: got %b expected 1", held); else passes++;
    if (pops - p0 !== 32) $display("FAIL pp_window_pops: got %0d expected 32", pops - p0); else passes++;
    pix_ready = 1'b1;
    repeat (40) tick();
    pix_ready = 1'b0;
    checks += 2;
    if (pops - p0 !== 42) $display("FAIL pp_remaining: got %0d expected 42", pops - p0); else passes++;
    if (exp_q.size() !== 0) $display("FAIL pp_left: got %0d expected 0", exp_q.size()); else passes++;
  endtask

`ifdef FETCH_UNDERRUN_CNT_EN
  task automatic test_underrun();
    ctl_mem_ready = 1'b0;
    pix_ready = 1'b0;
    restart_frame();
    pix_ready = 1'b1;
    repeat (5) tick();
    pix_ready = 1'b0;
    checks++;
    if (underrun_count !== 16'd5) $display("FAIL underrun: got %0d expected 5", underrun_count); else passes++;
    restart_frame();
    checks++;
    if (underrun_count !== 16'd0) $display("FAIL underrun_clr: got %0d expected 0", underrun_count); else passes++;
  endtask
`endif

  task automatic test_async_reset();
    int r0;
    pix_ready = 1'b0;
    ctl_mem_ready = 1'b1;
    r0 = req_count;
    restart_frame();
    wait_strobe(r0 + 1, "ar_req");
    ctl_mem_ready = 1'b0;
    for (int n = 0; n < 40 && !ctl_data_ready; n++) tick();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0) $display("FAIL ar_busy: got %b expected 0", busy); else passes++;
    if (pix_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", pix_valid); else passes++;
    if (pix_data !== 16'h0) $display("FAIL ar_data: got %0h expected 0", pix_data); else passes++;
    if (ctl_addr !== BASE) $display("FAIL ar_addr: got %0h expected %0h", ctl_addr, BASE); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    ctl_mem_ready = 1'b0;
    pix_ready = 1'b0;
    exp_addr = BASE;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_first_burst();
    test_two_bursts_wrap();
    test_restart_pending();
    test_push_pop_same_cycle();
`ifdef FETCH_UNDERRUN_CNT_EN
    test_underrun();
`endif
    test_async_reset();
    checks++;
    if (proto_errs !== 0) $display("FAIL protocol: got %0d bad strobes expected 0", proto_errs); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
